ins_fetch: RTL
==============

// Module: ins_fetch
// PURPOSE
//   Instruction fetch stage feeding the instruction decoder. Holds the PC, issues
//   reads to a synchronous instruction memory, registers the returned word with its
//   PC, and handles stall, branch/call redirect and HALT. Output ins_out drives the
//   decoder's ins input directly.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC of first fetch after reset
//   PC_INC    4              sequential PC increment (byte addressing)
// PORTS
//   clk             in   1   clock, all state updates on rising edge
//   rst_n           in   1   reset, asynchronous, active-low
//   stall           in   1   downstream not ready; freeze the fetch stage
//   redirect_valid  in   1   branch/call taken; load redirect_pc
//   redirect_pc     in   32  new fetch address
//   resume          in   1   leave HALTED and continue after the HALT
//   imem_en         out  1   memory read enable
//   imem_addr       out  32  memory read address (= pc_q)
//   imem_rdata      in   32  read data, valid 1 cycle after en; held while en=0
//   ins_out         out  32  registered instruction to decoder
//   ins_valid       out  1   ins_out is a live instruction
//   pc_out          out  32  PC of ins_out
//   npc_out         out  32  pc_out + PC_INC
//   halted          out  1   stage is in HALTED
//   misalign_err    out  1   sticky: redirect_pc[1:0] != 0 seen
// BEHAVIOUR
//   Reset (async): state=IDLE, pc_q=RESET_PC, inflight=0, ins_out=NOP (32'h9400_0000),
//     ins_valid=0, pc_out=0, npc_out=PC_INC, halted=0, misalign_err=0, imem_en=0.
//   States: IDLE -> RUN on first edge after reset release (unconditional).
//     RUN -> HALTED when a captured word has opcode [31:26]=6'b100100.
//     HALTED -> RUN on resume=1 or redirect_valid=1.
//   imem_en = (state==RUN) & !stall & !redirect_valid; imem_addr = pc_q always.
//   RUN, no stall, no redirect, per edge: pc_q<=pc_q+PC_INC; inflight<=1;
//     inflight_pc<=pc_q; if inflight: ins_out<=imem_rdata, pc_out<=inflight_pc,
//     ins_valid<=1; else ins_out<=NOP, ins_valid<=0.
//   Latency: address issued in cycle t -> ins_valid/ins_out visible in cycle t+2.
//     Steady state: one instruction per cycle.
//   Stall (RUN): all registers hold, imem_en=0; in-flight word is captured after
//     release (memory holds rdata). No drop, no duplicate.
//   Redirect (any state, overrides stall, resume, HALT capture): pc_q<={redirect_pc
//     [31:2],2'b00}; inflight<=0; ins_out<=NOP; ins_valid<=0; state<=RUN;
//     misalign_err<=misalign_err|(redirect_pc[1:0]!=0). Target valid 3 cycles after.
//   HALT capture: ins_out<=HALT word, ins_valid<=1 for one cycle, inflight<=0,
//     pc_q<=inflight_pc+PC_INC, state<=HALTED. In HALTED: imem_en=0, ins_valid=0,
//     ins_out=NOP, halted=1, stall ignored.
//   Resume in HALTED (no redirect): state<=RUN; fetch restarts at pc_q.
//   PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 silently.
//   rst_n low mid-operation: all outputs take reset values immediately.
// TESTING
//   Reset release, imem[0,4,8]=ADDI words -> ins_valid high 3 cycles after release
//     (IDLE, issue, capture); pc_out 0,4,8 on consecutive cycles, npc_out=pc_out+4.
//   stall=1 for 3 cycles while pc_out=4 -> ins_out/pc_out frozen, imem_en=0;
//     after release next pc_out=8, no gap-free duplicate of 4.
//   redirect_valid=1, redirect_pc=0x40 while 0x10 in flight -> 0x10 never valid;
//     ins_valid low 2 cycles; next valid pc_out=0x40, then 0x44.
//   HALT at 0x0C -> one valid cycle with ins_out[31:26]=6'b100100, halted=1,
//     imem_en=0; resume pulse -> next valid pc_out=0x10.
//   redirect with stall=1, and redirect in cycle a HALT is captured -> redirect
//     wins, halted stays 0, fetch continues at target.
//   redirect_pc=0x42 -> fetch at 0x40, misalign_err=1 until rst_n; rst_n pulsed
//     mid-stream -> ins_valid=0, ins_out=32'h9400_0000 asynchronously.

Source files
------------

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - instruction fetch stage: PC, synchronous imem read, stall/redirect/HALT
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_stall                   downstream not ready; freeze the fetch stage
//   i_redirect_valid/_pc      branch/call taken; restart fetch at word-aligned target
//   i_resume                  leave HALTED and continue after the HALT
//   o_imem_en, o_imem_addr    read request to synchronous instruction memory
//   i_imem_rdata              read data, one cycle after enable, held while idle
//   o_ins_out, o_ins_valid    registered instruction to decoder
//   o_pc_out, o_npc_out       PC of o_ins_out and its sequential successor
//   o_halted                  stage is in HALTED
//   o_misalign_err            sticky: misaligned redirect target seen
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect_valid,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_resume,
  output logic        o_imem_en,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  output logic [31:0] o_ins_out,
  output logic        o_ins_valid,
  output logic [31:0] o_pc_out,
  output logic [31:0] o_npc_out,
  output logic        o_halted,
  output logic        o_misalign_err
);

  localparam logic [31:0] NOP     = 32'h9400_0000;
  localparam logic [5:0]  HALT_OP = 6'b100100;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc_q;
  logic        r_inflight;
  logic [31:0] r_inflight_pc;
  logic [31:0] r_ins_out;
  logic        r_ins_valid;
  logic [31:0] r_pc_out;
  logic        r_misalign_err;

  // Fetch advances only in RUN with no stall and no redirect; this is also the
  // memory enable, so a stalled read leaves rdata untouched for later capture.
  logic w_advance;
  logic w_halt_cap;

  assign w_advance  = (r_state == S_RUN) && !i_stall && !i_redirect_valid;
  assign w_halt_cap = w_advance && r_inflight && (i_imem_rdata[31:26] == HALT_OP);

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; redirect beats everything, including a HALT capture
  always_comb begin
    w_state_nxt = r_state;
    if (i_redirect_valid) begin
      w_state_nxt = S_RUN;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_RUN;
        S_RUN:    if (w_halt_cap) w_state_nxt = S_HALTED;
        S_HALTED: if (i_resume) w_state_nxt = S_RUN;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    o_imem_en = w_advance;
    o_halted  = (r_state == S_HALTED);
  end

  // Datapath
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc_q         <= RESET_PC;
      r_inflight     <= 1'b0;
      r_inflight_pc  <= 32'h0;
      r_ins_out      <= NOP;
      r_ins_valid    <= 1'b0;
      r_pc_out       <= 32'h0;
      r_misalign_err <= 1'b0;
    end else if (i_redirect_valid) begin
      // The word in flight belongs to the old path and is dropped.
      r_pc_q         <= {i_redirect_pc[31:2], 2'b00};
      r_inflight     <= 1'b0;
      r_ins_out      <= NOP;
      r_ins_valid    <= 1'b0;
      r_misalign_err <= r_misalign_err | (i_redirect_pc[1:0] != 2'b00);
    end else if (w_advance) begin
      if (r_inflight) begin
        r_ins_out   <= i_imem_rdata;
        r_pc_out    <= r_inflight_pc;
        r_ins_valid <= 1'b1;
      end else begin
        r_ins_out   <= NOP;
        r_ins_valid <= 1'b0;
      end
      if (w_halt_cap) begin
        // Discard the fetch issued this cycle; resume restarts right after the HALT.
        r_inflight <= 1'b0;
        r_pc_q     <= r_inflight_pc + PC_INC;
      end else begin
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc_q;
        r_pc_q        <= r_pc_q + PC_INC;
      end
    end else if (r_state == S_HALTED) begin
      r_ins_out   <= NOP;
      r_ins_valid <= 1'b0;
    end
  end

  assign o_imem_addr    = r_pc_q;
  assign o_ins_out      = r_ins_out;
  assign o_ins_valid    = r_ins_valid;
  assign o_pc_out       = r_pc_out;
  assign o_npc_out      = r_pc_out + PC_INC;
  assign o_misalign_err = r_misalign_err;

endmodule
